edge_detector_bank: RTL and testbench

//  Multi-channel, parametrised edge detector: the successor to the single-bit posedge detector.
//  Per channel: optional input synchroniser, glitch filter, run-time edge mode (rise/fall/both),

---
 rtl/edge_det_pkg.sv | 16 +
 rtl/edge_detector_chan.sv | 119 +++++++++++
 rtl/edge_detector_bank.sv | 50 +++++
 tb/tb_edge_detector_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - edge mode encoding and filter counter width helper
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  // Filter counter must hold 0..FILTER_LEN-1; one spare code keeps FILTER_LEN=1 legal
  function automatic int fcnt_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/edge_detector_chan.sv
// rtl/edge_detector_chan.sv - one channel: synchroniser, glitch filter, edge detect, pending, counter
module edge_detector_chan
  import edge_det_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter int   CNT_W       = 16,
  parameter logic INIT_LVL    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             signal_i,
  input  edge_mode_t       mode_i,
  input  logic             pend_clr_i,
  input  logic             cnt_clr_i,
  output logic             edge_o,
  output logic             level_o,
  output logic             pend_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int                 FCNT_W    = fcnt_width(FILTER_LEN);
  localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic              synced;
  logic [FCNT_W-1:0] fcnt_q;
  logic              level_q;
  logic              prev_q;
  logic              edge_q;
  logic              pend_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rise;
  logic              fall;
  logic              edge_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = signal_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync_q <= {SYNC_STAGES{INIT_LVL}};
        end else begin
          sync_q[0] <= signal_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Level only follows the input after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt_q  <= '0;
      level_q <= INIT_LVL;
    end else if (synced == level_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCNT_LAST) begin
      fcnt_q  <= '0;
      level_q <= synced;
    end else begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  always_comb begin
    rise   = level_q & ~prev_q;
    fall   = ~level_q & prev_q;
    edge_d = 1'b0;
    case (mode_i)
      EDGE_RISE: edge_d = rise;
      EDGE_FALL: edge_d = fall;
      EDGE_BOTH: edge_d = rise | fall;
      default:   edge_d = 1'b0;
    endcase
  end

  // prev tracks level unconditionally so a mode switch cannot fabricate an edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= INIT_LVL;
      edge_q <= 1'b0;
    end else begin
      prev_q <= level_q;
      edge_q <= edge_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
    end else if (edge_q) begin
      pend_q <= 1'b1;
    end else if (pend_clr_i) begin
      pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= edge_q ? CNT_W'(1) : '0;
    end else if (edge_q && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign edge_o  = edge_q;
  assign level_o = level_q;
  assign pend_o  = pend_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/edge_detector_bank.sv
// rtl/edge_detector_bank.sv - CH independent edge detector channels with masked OR interrupt
module edge_detector_bank
  import edge_det_pkg::*;
#(
  parameter int   CH          = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter int   CNT_W       = 16,
  parameter logic INIT_LVL    = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CH-1:0]             signal_i,
  input  edge_mode_t [CH-1:0]       mode_i,
  input  logic [CH-1:0]             irq_mask_i,
  input  logic [CH-1:0]             pend_clr_i,
  input  logic [CH-1:0]             cnt_clr_i,
  output logic [CH-1:0]             edge_o,
  output logic [CH-1:0]             level_o,
  output logic [CH-1:0]             pend_o,
  output logic [CH-1:0][CNT_W-1:0]  cnt_o,
  output logic                      irq_o
);

  generate
    for (genvar g = 0; g < CH; g++) begin : g_chan
      edge_detector_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .CNT_W       (CNT_W),
        .INIT_LVL    (INIT_LVL)
      ) u_chan (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .signal_i   (signal_i[g]),
        .mode_i     (mode_i[g]),
        .pend_clr_i (pend_clr_i[g]),
        .cnt_clr_i  (cnt_clr_i[g]),
        .edge_o     (edge_o[g]),
        .level_o    (level_o[g]),
        .pend_o     (pend_o[g]),
        .cnt_o      (cnt_o[g])
      );
    end
  endgenerate

  // Combinational so unmasking an already-pending channel is visible immediately
  assign irq_o = |(pend_o & irq_mask_i);

endmodule

// File: tb/tb_edge_detector_bank.sv
// tb/tb_edge_detector_bank.sv - self-checking bench for edge_detector_bank
module tb_edge_detector_bank;
  import edge_det_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A: CH=4 SYNC=2 FILTER=1 CNT_W=16 INIT=0
  logic [3:0]        a_sig, a_mask, a_pclr, a_cclr, a_edge, a_level, a_pend;
  edge_mode_t [3:0]  a_mode;
  logic [3:0][15:0]  a_cnt;
  logic              a_irq;
  // B: CH=4 SYNC=0 FILTER=4 CNT_W=3 INIT=0
  logic [3:0]        b_sig, b_mask, b_pclr, b_cclr, b_edge, b_level, b_pend;
  edge_mode_t [3:0]  b_mode;
  logic [3:0][2:0]   b_cnt;
  logic              b_irq;
  // C: CH=1 SYNC=2 FILTER=1 INIT=1
  logic [0:0]        c_sig, c_mask, c_pclr, c_cclr, c_edge, c_level, c_pend;
  edge_mode_t [0:0]  c_mode;
  logic [0:0][15:0]  c_cnt;
  logic              c_irq;

  edge_detector_bank #(.CH(4), .SYNC_STAGES(2), .FILTER_LEN(1), .CNT_W(16), .INIT_LVL(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .signal_i(a_sig), .mode_i(a_mode), .irq_mask_i(a_mask),
    .pend_clr_i(a_pclr), .cnt_clr_i(a_cclr), .edge_o(a_edge), .level_o(a_level),
    .pend_o(a_pend), .cnt_o(a_cnt), .irq_o(a_irq));

  edge_detector_bank #(.CH(4), .SYNC_STAGES(0), .FILTER_LEN(4), .CNT_W(3), .INIT_LVL(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .signal_i(b_sig), .mode_i(b_mode), .irq_mask_i(b_mask),
    .pend_clr_i(b_pclr), .cnt_clr_i(b_cclr), .edge_o(b_edge), .level_o(b_level),
    .pend_o(b_pend), .cnt_o(b_cnt), .irq_o(b_irq));

  edge_detector_bank #(.CH(1), .SYNC_STAGES(2), .FILTER_LEN(1), .CNT_W(16), .INIT_LVL(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .signal_i(c_sig), .mode_i(c_mode), .irq_mask_i(c_mask),
    .pend_clr_i(c_pclr), .cnt_clr_i(c_cclr), .edge_o(c_edge), .level_o(c_level),
    .pend_o(c_pend), .cnt_o(c_cnt), .irq_o(c_irq));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] sig;
    edge_mode_t mode;
    logic [3:0] exp_edge;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] edge_v;
  } sb_t;

  sb_t sbq[$];
  sb_t sb_e;

  // Scoreboard monitor: pops expected edge_o of bank A when its due cycle arrives
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      sb_e = sbq.pop_front();
      chk("table_edge", a_edge, sb_e.edge_v);
    end
  end

  vec_t tbl [10];
  int   cnt_exp [4];
  logic [3:0] acc;

  initial begin
    tbl[0] = '{4'b0001, EDGE_RISE, 4'b0000};
    tbl[1] = '{4'b0011, EDGE_FALL, 4'b0000};
    tbl[2] = '{4'b0010, EDGE_FALL, 4'b0001};
    tbl[3] = '{4'b1100, EDGE_BOTH, 4'b1110};
    tbl[4] = '{4'b1100, EDGE_NONE, 4'b0000};
    tbl[5] = '{4'b0101, EDGE_NONE, 4'b0000};
    tbl[6] = '{4'b0101, EDGE_BOTH, 4'b0000};
    tbl[7] = '{4'b1010, EDGE_RISE, 4'b1010};
    tbl[8] = '{4'b0000, EDGE_FALL, 4'b1010};
    tbl[9] = '{4'b0000, EDGE_BOTH, 4'b0000};

    rst = 1'b1;
    a_sig = '0; a_mask = '0; a_pclr = '0; a_cclr = '0;
    b_sig = '0; b_mask = '0; b_pclr = '0; b_cclr = '0;
    c_sig = 1'b1; c_mask = 1'b1; c_pclr = '0; c_cclr = '0;
    for (int i = 0; i < 4; i++) a_mode[i] = EDGE_RISE;
    b_mode[0] = EDGE_RISE; b_mode[1] = EDGE_FALL; b_mode[2] = EDGE_BOTH; b_mode[3] = EDGE_NONE;
    c_mode[0] = EDGE_BOTH;

    tick(3);
    chk("rst_a_edge", a_edge, 0);
    chk("rst_a_level", a_level, 0);
    chk("rst_a_pend", a_pend, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_irq", a_irq, 0);
    chk("rst_c_level", c_level, 1);
    rst = 1'b0;

    // INIT_LVL=1 with input held high: no rise after release
    acc = '0;
    for (int i = 0; i < 8; i++) begin tick(1); acc[0] = acc[0] | c_edge[0]; end
    chk("c_no_spurious", acc[0], 0);

    // Latency: change sampled at edge 0, pulse after edge 3 only
    a_sig = 4'b0001;
    for (int i = 0; i < 3; i++) begin tick(1); chk("lat_early", a_edge, 0); end
    tick(1); chk("lat_pulse", a_edge, 4'b0001);
    tick(1); chk("lat_single", a_edge, 0);
    chk("lat_pend", a_pend, 4'b0001);
    chk("lat_cnt", a_cnt[0], 1);

    cnt_exp = '{1, 0, 0, 0};
    for (int v = 0; v < 10; v++) begin
      a_sig = tbl[v].sig;
      for (int c = 0; c < 4; c++) begin
        a_mode[c] = tbl[v].mode;
        cnt_exp[c] += int'(tbl[v].exp_edge[c]);
      end
      sbq.push_back('{cyc + 4, tbl[v].exp_edge});
      sbq.push_back('{cyc + 5, 4'b0000});
      tick(4);
    end
    tick(3);
    chk("sb_drained", sbq.size(), 0);
    for (int c = 0; c < 4; c++) chk($sformatf("tbl_cnt%0d", c), a_cnt[c], cnt_exp[c]);
    chk("tbl_pend", a_pend, 4'b1111);

    // Clear alone, then clear coincident with edge: set wins, counter restarts at 1
    a_pclr = 4'b0010; tick(1); a_pclr = '0;
    chk("pclr_alone", a_pend, 4'b1101);
    for (int c = 0; c < 4; c++) a_mode[c] = EDGE_RISE;
    a_sig = 4'b0010;
    tick(4); chk("coinc_edge", a_edge, 4'b0010);
    a_pclr = 4'b0010; a_cclr = 4'b0010;
    tick(1); a_pclr = '0; a_cclr = '0;
    chk("coinc_pend", a_pend[1], 1);
    chk("coinc_cnt", a_cnt[1], 1);
    a_cclr = 4'b1000; tick(1); a_cclr = '0;
    chk("cclr_alone", a_cnt[3], 0);

    // irq masking is combinational
    a_mask = '0; #1;
    chk("irq_masked", a_irq, 0);
    a_mask = 4'b1000; #1;
    chk("irq_unmask", a_irq, 1);
    a_pclr = 4'b1000; tick(1); a_pclr = '0;
    chk("irq_cleared", a_irq, 0);

    for (int c = 0; c < 4; c++) a_mode[c] = EDGE_BOTH;
    a_cclr = 4'b0100; tick(1); a_cclr = '0;
    for (int i = 0; i < 10; i++) begin a_sig[2] = ~a_sig[2]; tick(8); end
    chk("toggle_cnt10", a_cnt[2], 10);

    // Bank B: 3-cycle glitch is swallowed by the 4-sample filter
    acc = '0;
    b_sig = 4'b1111;
    for (int i = 0; i < 3; i++) begin tick(1); acc = acc | b_edge | b_level; end
    b_sig = 4'b0000;
    for (int i = 0; i < 8; i++) begin tick(1); acc = acc | b_edge | b_level; end
    chk("glitch_ignored", acc, 0);
    b_sig = 4'b1111;
    tick(4); chk("filt_level", b_level, 4'b1111);
    b_sig = 4'b0000;
    tick(1); chk("filt_rise", b_edge, 4'b0101);
    tick(12);
    chk("filt_level_low", b_level, 0);
    chk("filt_cnt0", b_cnt[0], 1);
    chk("filt_cnt1", b_cnt[1], 1);
    chk("filt_cnt2", b_cnt[2], 2);
    chk("filt_cnt3", b_cnt[3], 0);

    b_cclr = 4'b1111; tick(1); b_cclr = '0;
    for (int i = 0; i < 9; i++) begin b_sig = ~b_sig; tick(6); end
    tick(4);
    chk("sat_cnt0", b_cnt[0], 5);
    chk("sat_cnt1", b_cnt[1], 4);
    chk("sat_cnt2", b_cnt[2], 7);
    chk("sat_cnt3", b_cnt[3], 0);

    c_sig = 1'b0; tick(6);
    chk("c_fall_cnt", c_cnt[0], 1);
    c_sig = 1'b1; tick(6);
    chk("c_rise_cnt", c_cnt[0], 2);

    // Reset mid-filter and with A edges in flight
    b_sig = 4'b0000; a_sig = 4'b0000;
    tick(2);
    rst = 1'b1; tick(1);
    chk("mrst_a", {a_edge, a_level, a_pend, a_irq}, 0);
    chk("mrst_a_cnt", a_cnt, 0);
    chk("mrst_b", {b_edge, b_level, b_pend, b_irq}, 0);
    chk("mrst_b_cnt", b_cnt, 0);
    chk("mrst_c", {c_edge, c_pend, c_cnt}, 0);
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      acc = acc | a_edge | b_edge | a_pend | b_pend | {3'b000, c_edge[0] | c_pend[0]};
    end
    chk("post_rst_quiet", acc, 0);
    chk("post_rst_c_level", c_level, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
